// File: rtl/sdram_resp_model.sv
// rtl/sdram_resp_model.sv - SDR SDRAM device responder: command decode, bank tracking, burst storage, CL-delayed reads
// Violations are flagged through a sticky error code and leave state and storage untouched.
module sdram_resp_model #(
   parameter int ROW_WIDTH      = 12,
   parameter int COL_WIDTH      = 8,
   parameter int BA_WIDTH       = 2,
   parameter int DQ_WIDTH       = 16,
   parameter int MEM_ADDR_WIDTH = 12
) (
   input  logic                    sdram_clk,
   input  logic                    sdram_rst_n,
   input  logic                    sdram_cke_i,
   input  logic                    sdram_cs_n_i,
   input  logic                    sdram_ras_i,
   input  logic                    sdram_cas_i,
   input  logic                    sdram_we_i,
   input  logic [BA_WIDTH-1:0]     sdram_ba_i,
   input  logic [ROW_WIDTH-1:0]    sdram_a_i,
   input  logic [DQ_WIDTH/8-1:0]   sdram_dqm_i,
   input  logic [DQ_WIDTH-1:0]     sdram_dq_i,
   output logic [DQ_WIDTH-1:0]     sdram_dq_o,
   output logic                    sdram_dq_oe,
   output logic                    mode_valid_o,
   output logic                    err_o,
   output logic [2:0]              err_code_o
);

   localparam int NB  = 1 << BA_WIDTH;
   localparam int NL  = DQ_WIDTH / 8;
   localparam int BLW = $clog2(COL_WIDTH + 1);

   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_MRS = 3'b000;
   localparam logic [2:0] CMD_BST = 3'b110;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_BAD_MRS  = 3'd1;
   localparam logic [2:0] ERR_NO_MODE  = 3'd2;
   localparam logic [2:0] ERR_ACT_OPEN = 3'd3;
   localparam logic [2:0] ERR_CLOSED   = 3'd4;
   localparam logic [2:0] ERR_REF_OPEN = 3'd5;
   localparam logic [2:0] ERR_MRS_OPEN = 3'd6;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;

   function automatic logic [MEM_ADDR_WIDTH-1:0] idx_of(
      input logic [BA_WIDTH-1:0]  ba,
      input logic [ROW_WIDTH-1:0] row,
      input logic [COL_WIDTH-1:0] col
   );
      return MEM_ADDR_WIDTH'({ba, row, col});
   endfunction

   logic [DQ_WIDTH-1:0]       mem_q [0:(1<<MEM_ADDR_WIDTH)-1];

   logic                      mode_valid_q, mode_valid_d;
   logic [BLW-1:0]            bl_log_q, bl_log_d;
   logic                      cl3_q, cl3_d;
   logic [NB-1:0]             bank_open_q, bank_open_d;
   logic [ROW_WIDTH-1:0]      bank_row_q [NB];
   logic [ROW_WIDTH-1:0]      bank_row_d [NB];
   logic [1:0]                st_q, st_d;
   logic [BA_WIDTH-1:0]       bba_q, bba_d;
   logic [ROW_WIDTH-1:0]      brow_q, brow_d;
   logic [COL_WIDTH-1:0]      bcol_q, bcol_d;
   logic [COL_WIDTH-1:0]      bbeat_q, bbeat_d;
   logic                      bap_q, bap_d;
   logic [2:0]                pv_q, pv_d;
   logic [MEM_ADDR_WIDTH-1:0] pidx_q [3];
   logic [MEM_ADDR_WIDTH-1:0] pidx_d [3];
   logic [DQ_WIDTH-1:0]       dq_q, dq_d;
   logic                      oe_q, oe_d;
   logic                      err_q, err_d;
   logic [2:0]                errc_q, errc_d;

   logic [2:0]                cmd;
   logic                      cmd_en;
   logic                      legal;
   logic                      take_rw;
   logic                      take_bst;
   logic [2:0]                err_new;
   logic                      mrs_bad;
   logic [BLW-1:0]            mrs_bl;
   logic [COL_WIDTH-1:0]      bl_mask;
   logic [COL_WIDTH-1:0]      eng_col;
   logic [MEM_ADDR_WIDTH-1:0] cmd_idx;
   logic                      rd_go;
   logic [MEM_ADDR_WIDTH-1:0] rd_idx;
   logic                      mem_we;
   logic [MEM_ADDR_WIDTH-1:0] mem_widx;
   logic [DQ_WIDTH-1:0]       mem_wdata;
   logic [NL-1:0]             mem_wmask;

   always_comb begin
      cmd     = {sdram_ras_i, sdram_cas_i, sdram_we_i};
      cmd_en  = sdram_cke_i && !sdram_cs_n_i && (cmd != CMD_NOP);
      bl_mask = ~({COL_WIDTH{1'b1}} << bl_log_q);
      // Burst column wraps inside the BL-aligned block around the start column.
      eng_col = (bcol_q & ~bl_mask) | ((bcol_q + bbeat_q) & bl_mask);

      mrs_bl  = '0;
      mrs_bad = 1'b0;
      case (sdram_a_i[2:0])
         3'd0, 3'd1, 3'd2, 3'd3: mrs_bl = BLW'(sdram_a_i[1:0]);
         3'd7:                   mrs_bl = BLW'(COL_WIDTH);
         default:                mrs_bad = 1'b1;
      endcase
      if (sdram_a_i[6:4] != 3'd2 && sdram_a_i[6:4] != 3'd3) mrs_bad = 1'b1;

      err_new = ERR_NONE;
      if (cmd_en) begin
         if (cmd == CMD_MRS) begin
            if (|bank_open_q)  err_new = ERR_MRS_OPEN;
            else if (mrs_bad)  err_new = ERR_BAD_MRS;
         end else if (!mode_valid_q) begin
            err_new = ERR_NO_MODE;
         end else if (cmd == CMD_ACT && bank_open_q[sdram_ba_i]) begin
            err_new = ERR_ACT_OPEN;
         end else if ((cmd == CMD_RD || cmd == CMD_WR) && !bank_open_q[sdram_ba_i]) begin
            err_new = ERR_CLOSED;
         end else if (cmd == CMD_REF && |bank_open_q) begin
            err_new = ERR_REF_OPEN;
         end
      end
      legal    = cmd_en && (err_new == ERR_NONE);
      take_rw  = legal && (cmd == CMD_RD || cmd == CMD_WR);
      take_bst = legal && (cmd == CMD_BST);

      mode_valid_d = mode_valid_q;
      bl_log_d     = bl_log_q;
      cl3_d        = cl3_q;
      bank_open_d  = bank_open_q;
      bank_row_d   = bank_row_q;
      st_d         = st_q;
      bba_d        = bba_q;
      brow_d       = brow_q;
      bcol_d       = bcol_q;
      bbeat_d      = bbeat_q;
      bap_d        = bap_q;
      pv_d         = pv_q;
      pidx_d       = pidx_q;
      dq_d         = dq_q;
      oe_d         = oe_q;
      err_d        = err_q;
      errc_d       = errc_q;
      cmd_idx      = '0;
      rd_go        = 1'b0;
      rd_idx       = '0;
      mem_we       = 1'b0;
      mem_widx     = '0;
      mem_wdata    = '0;
      mem_wmask    = '1;

      if (sdram_cke_i) begin
         pv_d      = {1'b0, pv_q[2:1]};
         pidx_d[0] = pidx_q[1];
         pidx_d[1] = pidx_q[2];
         oe_d      = pv_q[0];
         dq_d      = pv_q[0] ? mem_q[pidx_q[0]] : '0;

         if (st_q != ST_IDLE && !take_rw && !take_bst) begin
            if (st_q == ST_WR) begin
               mem_we    = 1'b1;
               mem_widx  = idx_of(bba_q, brow_q, eng_col);
               mem_wdata = sdram_dq_i;
               mem_wmask = sdram_dqm_i;
            end else begin
               rd_go  = 1'b1;
               rd_idx = idx_of(bba_q, brow_q, eng_col);
            end
            bbeat_d = bbeat_q + COL_WIDTH'(1);
            if (bbeat_q == bl_mask) begin
               st_d = ST_IDLE;
               if (bap_q) bank_open_d[bba_q] = 1'b0;
            end
         end

         if (legal) begin
            case (cmd)
               CMD_ACT: begin
                  bank_open_d[sdram_ba_i] = 1'b1;
                  bank_row_d[sdram_ba_i]  = sdram_a_i;
               end
               CMD_PRE: begin
                  if (sdram_a_i[10]) bank_open_d = '0;
                  else               bank_open_d[sdram_ba_i] = 1'b0;
               end
               CMD_MRS: begin
                  mode_valid_d = 1'b1;
                  bl_log_d     = mrs_bl;
                  cl3_d        = sdram_a_i[4];
               end
               CMD_BST: st_d = ST_IDLE;
               CMD_RD, CMD_WR: begin
                  cmd_idx = idx_of(sdram_ba_i, bank_row_q[sdram_ba_i], sdram_a_i[COL_WIDTH-1:0]);
                  if (cmd == CMD_WR) begin
                     // A write takes the bus back: every pending read beat is dropped.
                     pv_d      = '0;
                     oe_d      = 1'b0;
                     dq_d      = '0;
                     mem_we    = 1'b1;
                     mem_widx  = cmd_idx;
                     mem_wdata = sdram_dq_i;
                     mem_wmask = sdram_dqm_i;
                  end else begin
                     rd_go  = 1'b1;
                     rd_idx = cmd_idx;
                  end
                  bba_d   = sdram_ba_i;
                  brow_d  = bank_row_q[sdram_ba_i];
                  bcol_d  = sdram_a_i[COL_WIDTH-1:0];
                  bbeat_d = COL_WIDTH'(1);
                  bap_d   = sdram_a_i[10];
                  if (bl_mask == '0) begin
                     st_d = ST_IDLE;
                     if (sdram_a_i[10]) bank_open_d[sdram_ba_i] = 1'b0;
                  end else begin
                     st_d = (cmd == CMD_WR) ? ST_WR : ST_RD;
                  end
               end
               default: ;
            endcase
         end

         // A beat issued now must surface CL edges later; stage cl-1 gives that.
         if (rd_go) begin
            if (cl3_q) begin
               pv_d[2]   = 1'b1;
               pidx_d[2] = rd_idx;
            end else begin
               pv_d[1]   = 1'b1;
               pidx_d[1] = rd_idx;
            end
         end

         if (err_new != ERR_NONE && !err_q) begin
            err_d  = 1'b1;
            errc_d = err_new;
         end
      end
   end

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         mode_valid_q <= 1'b0;
         bl_log_q     <= '0;
         cl3_q        <= 1'b0;
         bank_open_q  <= '0;
         for (int b = 0; b < NB; b++) bank_row_q[b] <= '0;
         st_q         <= ST_IDLE;
         bba_q        <= '0;
         brow_q       <= '0;
         bcol_q       <= '0;
         bbeat_q      <= '0;
         bap_q        <= 1'b0;
         pv_q         <= '0;
         for (int s = 0; s < 3; s++) pidx_q[s] <= '0;
         dq_q         <= '0;
         oe_q         <= 1'b0;
         err_q        <= 1'b0;
         errc_q       <= '0;
      end else begin
         mode_valid_q <= mode_valid_d;
         bl_log_q     <= bl_log_d;
         cl3_q        <= cl3_d;
         bank_open_q  <= bank_open_d;
         bank_row_q   <= bank_row_d;
         st_q         <= st_d;
         bba_q        <= bba_d;
         brow_q       <= brow_d;
         bcol_q       <= bcol_d;
         bbeat_q      <= bbeat_d;
         bap_q        <= bap_d;
         pv_q         <= pv_d;
         pidx_q       <= pidx_d;
         dq_q         <= dq_d;
         oe_q         <= oe_d;
         err_q        <= err_d;
         errc_q       <= errc_d;
      end
   end

   // Storage survives reset, so it lives outside the reset domain.
   always_ff @(posedge sdram_clk) begin
      if (mem_we) begin
         for (int l = 0; l < NL; l++) begin
            if (!mem_wmask[l]) mem_q[mem_widx][8*l +: 8] <= mem_wdata[8*l +: 8];
         end
      end
   end

   assign sdram_dq_o   = dq_q;
   assign sdram_dq_oe  = oe_q;
   assign mode_valid_o = mode_valid_q;
   assign err_o        = err_q;
   assign err_code_o   = errc_q;

endmodule
